// File: rtl/reg_file_wb.sv
// 32 x 64-bit register file with write-back decode, hardwired XZR and a
// per-register busy scoreboard. Define REGFILE_BYPASS_EN for write-through reads.
module reg_file_wb_cell #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              set_busy,
  input  logic              clr_busy,
  output logic [DATA_W-1:0] q,
  output logic              busy
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (we)  q <= wdata;
  end

  // Set beats clear: a new long-latency op re-targets the register being written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      busy <= 1'b0;
    else if (set_busy) busy <= 1'b1;
    else if (clr_busy) busy <= 1'b0;
  end
endmodule

module reg_file_wb #(
  parameter int DATA_W   = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              MarkBusy,
  input  logic [4:0]        BusyRegister,
  output logic              Busy1,
  output logic              Busy2,
  output logic              AnyBusy
);
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             busy;
  logic [NREGS-1:0]             we;
  logic [NREGS-1:0]             mark;

  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : g_reg
      assign we[i]   = RegWrite && (WriteRegister == 5'(i));
      assign mark[i] = MarkBusy && (BusyRegister == 5'(i));
      if (i == ZERO_REG) begin : g_zero
        assign regs[i] = '0;
        assign busy[i] = 1'b0;
      end else begin : g_cell
        reg_file_wb_cell #(.DATA_W(DATA_W)) u_cell (
          .clk      (clk),
          .reset_n  (reset_n),
          .we       (we[i]),
          .wdata    (WriteData),
          .set_busy (mark[i]),
          .clr_busy (we[i]),
          .q        (regs[i]),
          .busy     (busy[i])
        );
      end
    end
  endgenerate

  assign AnyBusy = |busy;

`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1 = RegWrite && (WriteRegister == ReadRegister1) &&
                (WriteRegister != 5'(ZERO_REG));
  assign fwd2 = RegWrite && (WriteRegister == ReadRegister2) &&
                (WriteRegister != 5'(ZERO_REG));
  assign ReadData1 = fwd1 ? WriteData : regs[ReadRegister1];
  assign ReadData2 = fwd2 ? WriteData : regs[ReadRegister2];
  assign Busy1     = busy[ReadRegister1] && !fwd1;
  assign Busy2     = busy[ReadRegister2] && !fwd2;
`else
  assign ReadData1 = regs[ReadRegister1];
  assign ReadData2 = regs[ReadRegister2];
  assign Busy1     = busy[ReadRegister1];
  assign Busy2     = busy[ReadRegister2];
`endif
endmodule

// File: tb/tb_reg_file_wb.sv
// Directed + randomized bench for reg_file_wb against an array-based model.
module tb_reg_file_wb;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [63:0] ReadData1, ReadData2;
  logic        MarkBusy;
  logic [4:0]  BusyRegister;
  logic        Busy1, Busy2, AnyBusy;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] m_reg [32];
  bit          m_busy[32];

  always #5 clk = ~clk;

  reg_file_wb dut (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .MarkBusy(MarkBusy),
    .BusyRegister(BusyRegister), .Busy1(Busy1), .Busy2(Busy2), .AnyBusy(AnyBusy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit fwd(input logic [4:0] ra);
`ifdef REGFILE_BYPASS_EN
    return RegWrite && WriteRegister == ra && ra != 5'd31;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] exp_rd(input logic [4:0] ra);
    if (fwd(ra)) return WriteData;
    return (ra == 5'd31) ? 64'd0 : m_reg[ra];
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra);
    if (fwd(ra) || ra == 5'd31) return 1'b0;
    return m_busy[ra];
  endfunction

  function automatic logic exp_any();
    logic a = 1'b0;
    for (int k = 0; k < 32; k++) a |= m_busy[k];
    return a;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 32; k++) begin m_reg[k] = '0; m_busy[k] = 1'b0; end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rd1"}, ReadData1, exp_rd(ReadRegister1));
    chk({tag, ".rd2"}, ReadData2, exp_rd(ReadRegister2));
    chk({tag, ".busy1"}, 64'(Busy1), 64'(exp_busy(ReadRegister1)));
    chk({tag, ".busy2"}, 64'(Busy2), 64'(exp_busy(ReadRegister2)));
    chk({tag, ".any"}, 64'(AnyBusy), 64'(exp_any()));
  endtask

  // Called just after a negedge: drive, check mid-cycle, clock, update model.
  task automatic step(input string tag, input logic rw, input logic [4:0] wr,
                      input logic [63:0] wd, input logic mb, input logic [4:0] br,
                      input logic [4:0] r1, input logic [4:0] r2);
    RegWrite = rw; WriteRegister = wr; WriteData = wd;
    MarkBusy = mb; BusyRegister = br;
    ReadRegister1 = r1; ReadRegister2 = r2;
    #1;
    check_outputs(tag);
    @(posedge clk);
    if (rw && wr != 5'd31) begin m_reg[wr] = wd; m_busy[wr] = 1'b0; end
    if (mb && br != 5'd31) m_busy[br] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; RegWrite = 0; WriteRegister = 0; WriteData = 0;
    MarkBusy = 0; BusyRegister = 0; ReadRegister1 = 5'd5; ReadRegister2 = 5'd9;
    model_clear();
    #1;
    check_outputs("reset0");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous reset mid-cycle, with a write in flight that must be lost
    step("rst_wr", 1, 5'd5, 64'hDEAD, 1, 5'd9, 5'd5, 5'd9);
    RegWrite = 0; MarkBusy = 0; ReadRegister1 = 5'd5; ReadRegister2 = 5'd9;
    #1;
    chk("rst_pre.rd1", ReadData1, 64'hDEAD);
    chk("rst_pre.busy2", 64'(Busy2), 64'd1);
    #1;
    reset_n = 1'b0;
    RegWrite = 1; WriteRegister = 5'd6; WriteData = 64'h77;
    #1;
    model_clear();
    chk("rst_async.rd1", ReadData1, 64'd0);
    chk("rst_async.busy2", 64'(Busy2), 64'd0);
    chk("rst_async.any", 64'(AnyBusy), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step("rst_post", 0, 5'd0, 64'd0, 0, 5'd0, 5'd6, 5'd5);

    // Write/read both ports, neighbours stay zero
    step("wr_x3", 1, 5'd3, 64'h0123456789ABCDEF, 0, 5'd0, 5'd3, 5'd3);
    step("rd_x3", 0, 5'd0, 64'd0, 0, 5'd0, 5'd3, 5'd3);
    step("rd_nb", 0, 5'd0, 64'd0, 0, 5'd0, 5'd2, 5'd4);

    // XZR write and MarkBusy both ignored
    step("xzr_w", 1, 5'd31, '1, 1, 5'd31, 5'd31, 5'd3);
    step("xzr_r", 0, 5'd0, 64'd0, 0, 5'd0, 5'd31, 5'd31);

    // Read during write on X7
    step("rdw_x7", 1, 5'd7, 64'h55, 0, 5'd0, 5'd7, 5'd3);
    step("rdw_nx", 0, 5'd0, 64'd0, 0, 5'd0, 5'd7, 5'd7);

    // Scoreboard set then clear by write
    step("sb_mark", 0, 5'd0, 64'd0, 1, 5'd9, 5'd9, 5'd0);
    step("sb_busy", 0, 5'd0, 64'd0, 0, 5'd0, 5'd9, 5'd0);
    step("sb_wr", 1, 5'd9, 64'h10, 0, 5'd0, 5'd9, 5'd0);
    step("sb_clr", 0, 5'd0, 64'd0, 0, 5'd0, 5'd9, 5'd9);

    // Set/clear collision on X4, double mark, then single clearing write
    step("col_m1", 0, 5'd0, 64'd0, 1, 5'd4, 5'd4, 5'd4);
    step("col_m2", 0, 5'd0, 64'd0, 1, 5'd4, 5'd4, 5'd0);
    step("col_sw", 1, 5'd4, 64'h22, 1, 5'd4, 5'd0, 5'd4);
    step("col_chk", 0, 5'd0, 64'd0, 0, 5'd0, 5'd4, 5'd4);
    step("col_wr", 1, 5'd4, 64'h33, 0, 5'd0, 5'd4, 5'd1);
    step("col_done", 0, 5'd0, 64'd0, 0, 5'd0, 5'd4, 5'd4);

    // Random traffic, biased toward address collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr, br, r1, r2;
      wr = 5'($urandom_range(0, 31));
      br = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? br : 5'($urandom_range(0, 31));
      step("rand", 1'($urandom_range(0, 1)), wr, {$urandom, $urandom},
           ($urandom_range(0, 2) == 0), br, r1, r2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32 x 64-bit architectural register file for the LEGv8-style datapath.
- It is the write/decode end of the operand-select path:
  - It accepts a write-back (5-bit address decoded to one of 32 write enables).
  - It sources ReadData1/ReadData2 into the ALU input-select logic.
- It includes a per-register busy scoreboard for multi-cycle producers (multiplier), so that decode can stall on RAW hazards.

Parameters:
- DATA_W, 64, register width
- NREGS, 32, register count (address width fixed at 5)
- ZERO_REG, 31, index of hardwired-zero register (XZR)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- RegWrite  input  1  write-back enable
- WriteRegister  input  5  write-back destination
- WriteData  input  64  write-back data
- ReadRegister1  input  5  read port 1 address
- ReadRegister2  input  5  read port 2 address
- ReadData1  output  64  read port 1 data
- ReadData2  output  64  read port 2 data
- MarkBusy  input  1  set busy bit for BusyRegister (multi-cycle op issued)
- BusyRegister  input  5  register to mark busy
- Busy1  output  1  ReadRegister1 has pending multi-cycle write
- Busy2  output  1  ReadRegister2 has pending multi-cycle write
- AnyBusy  output  1  OR of all busy bits

Behaviour:
- Reset (reset_n low, asynchronous):
  - All 32 registers clear to 0 and all busy bits clear to 0.
  - Outputs follow immediately: ReadData1=ReadData2=0, Busy1=Busy2=AnyBusy=0.
- Write: on posedge clk with RegWrite=1, reg[WriteRegister] <= WriteData.
  - The write decoder is a one-hot 5-to-32 decode gated by RegWrite.
  - Exactly one register is written per cycle.
- ZERO_REG:
  - Writes to ZERO_REG are discarded.
  - Reads of ZERO_REG always return 0.
  - Busy for ZERO_REG is never set (MarkBusy to 31 ignored).
- Reads: combinational (zero-cycle latency) from current register contents.
  - Without the optional feature, a write in cycle N is visible on reads from cycle N+1.
- Scoreboard:
  - busy[BusyRegister] sets on posedge clk when MarkBusy=1.
  - busy[WriteRegister] clears on posedge clk when RegWrite=1.
- Simultaneous MarkBusy and RegWrite to the same register in the same cycle: set wins, so busy=1 after the edge.
  - This models a new long-latency op re-targeting the register being written.
- MarkBusy to an already-busy register: stays busy (no counting). A single write clears it.
- Busy1/Busy2 are combinational lookups of busy[ReadRegister1/2]. AnyBusy is the OR-reduction.
- Reset asserted mid-operation:
  - Any in-flight write in that cycle is lost.
  - Busy bits clear.
  - Register contents are all 0 on release.
- The file never stalls and never rejects a write. Hazard handling is the consumer's job via Busy1/Busy2.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If RegWrite=1, WriteRegister==ReadRegisterN and WriteRegister!=ZERO_REG, then ReadDataN = WriteData in the same cycle.
  - BusyN is forced to 0 in that case, since the value is available now.
- Undefined:
  - Reads return the stored value only; the write is visible next cycle.
  - Busy reflects the stored busy bit.

Test Plan:
- Reset check: pulse reset_n low mid-cycle after writing X5=0xDEAD -> ReadData1 for X5 reads 0 immediately (asynchronous), and all Busy outputs are 0.
- Write/read: write X3=0x0123456789ABCDEF, then read X3 on port 1 and port 2 next cycle -> both 0x0123456789ABCDEF. Other registers remain 0.
- XZR: write X31=0xFFFFFFFFFFFFFFFF with MarkBusy on 31 -> ReadData for X31=0 and Busy=0.
- Same-cycle read-during-write on X7 with WriteData=0x55:
  - Bypass build -> ReadData1=0x55 in the same cycle.
  - Non-bypass build -> old value, then 0x55 next cycle.
- Scoreboard: MarkBusy X9, then read X9 -> Busy1=1 and AnyBusy=1. Write X9=0x10 -> Busy1=0 next cycle and ReadData1=0x10.
- Set/clear collision: with X4 busy, MarkBusy X4 and RegWrite X4=0x22 in the same cycle -> after the edge Busy=1 and reg X4=0x22. A following write of X4 clears Busy.
